// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: captures one frame into an external single-port RAM, then
// replays it forward, reversed or fftshifted while tracking the peak sample.
module frame_seq_ctrl #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW:0]   len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wren,
  output logic          ram_rden,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] max_val,
  output logic [AW-1:0] max_idx,
  output logic          err
);

  localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_REPLAY, S_DRAIN, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_k_q, rd_k_d;
  logic          first_q, first_d;
  logic          in_ready_q, in_ready_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_wren_q, ram_wren_d;
  logic          ram_rden_q, ram_rden_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          rd_last_q, rd_last_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] max_val_q, max_val_d;
  logic [AW-1:0] max_idx_q, max_idx_d;
  logic          err_q, err_d;

  logic [AW:0]   half;
  logic [AW:0]   shift_sum;
  logic [AW-1:0] rd_addr;

  // Replay address for step k; fftshift wraps by compare-and-subtract.
  always_comb begin
    half      = (len_q + ONE) >> 1;
    shift_sum = rd_k_q + half;
    unique case (mode_q)
      2'd1:    rd_addr = AW'(len_q - ONE - rd_k_q);
      2'd2:    rd_addr = AW'((shift_sum < len_q) ? shift_sum : shift_sum - len_q);
      default: rd_addr = AW'(rd_k_q);
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    mode_d      = mode_q;
    wr_ptr_d    = wr_ptr_q;
    rd_k_d      = rd_k_q;
    first_d     = first_q;
    in_ready_d  = 1'b0;
    ram_addr_d  = '0;
    ram_wren_d  = 1'b0;
    ram_rden_d  = 1'b0;
    ram_wdata_d = '0;
    rd_last_d   = 1'b0;
    out_valid_d = ram_rden_q;
    out_idx_d   = ram_rden_q ? ram_addr_q : '0;
    out_last_d  = rd_last_q;
    busy_d      = (state_q != S_IDLE);
    done_d      = (state_q == S_DONE);
    max_val_d   = max_val_q;
    max_idx_d   = max_idx_q;
    err_d       = 1'b0;

    // First replayed sample loads unconditionally; ties keep the earlier one.
    if (out_valid_q && (first_q || (ram_rdata > max_val_q))) begin
      max_val_d = ram_rdata;
      max_idx_d = out_idx_q;
      first_d   = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((len != '0) && (len <= CAP)) begin
            len_d      = len;
            mode_d     = mode;
            wr_ptr_d   = '0;
            rd_k_d     = '0;
            first_d    = 1'b1;
            max_val_d  = '0;
            max_idx_d  = '0;
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
            state_d    = S_CAPTURE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        in_ready_d = 1'b1;
        if (in_valid) begin
          ram_wren_d  = 1'b1;
          ram_addr_d  = AW'(wr_ptr_q);
          ram_wdata_d = in_data;
          wr_ptr_d    = wr_ptr_q + ONE;
          if (wr_ptr_q == len_q - ONE) begin
            in_ready_d = 1'b0;
            state_d    = S_REPLAY;
          end
        end
      end
      S_REPLAY: begin
        ram_rden_d = 1'b1;
        ram_addr_d = rd_addr;
        if (rd_k_q == len_q - ONE) begin
          rd_last_d = 1'b1;
          state_d   = S_DRAIN;
        end else begin
          rd_k_d = rd_k_q + ONE;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      mode_q      <= '0;
      wr_ptr_q    <= '0;
      rd_k_q      <= '0;
      first_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wren_q  <= 1'b0;
      ram_rden_q  <= 1'b0;
      ram_wdata_q <= '0;
      rd_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_k_q      <= rd_k_d;
      first_q     <= first_d;
      in_ready_q  <= in_ready_d;
      ram_addr_q  <= ram_addr_d;
      ram_wren_q  <= ram_wren_d;
      ram_rden_q  <= ram_rden_d;
      ram_wdata_q <= ram_wdata_d;
      rd_last_q   <= rd_last_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      max_val_q   <= max_val_d;
      max_idx_q   <= max_idx_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wren  = ram_wren_q;
  assign ram_rden  = ram_rden_q;
  assign ram_wdata = ram_wdata_q;
  assign out_valid = out_valid_q;
  // RAM data arrives one cycle after the read, aligned with out_valid.
  assign out_data  = out_valid_q ? ram_rdata : '0;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign max_val   = max_val_q;
  assign max_idx   = max_idx_q;
  assign err       = err_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Scoreboard bench for frame_seq_ctrl with a 1-cycle-latency RAM model.
module tb_frame_seq_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 11;
  localparam int CAP = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode_i = '0;
  logic [AW:0]   len_i = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_wren, ram_rden;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last, busy, done, err;
  logic [DW-1:0] max_val;
  logic [AW-1:0] max_idx;

  frame_seq_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode_i), .len(len_i),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_rden(ram_rden),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done),
    .max_val(max_val), .max_idx(max_idx), .err(err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [CAP];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    if (ram_rden) ram_rdata <= mem[ram_addr];
  end

  logic [88:0] all_out;
  assign all_out = {in_ready, ram_addr, ram_wren, ram_rden, ram_wdata, out_valid,
                    out_data, out_idx, out_last, busy, done, max_val, max_idx, err};

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] i;
    logic          l;
  } smp_t;

  smp_t          exp_q[$];
  smp_t          obs_q[$];
  logic [DW-1:0] stim [CAP];
  logic [DW-1:0] exp_max_v;
  logic [AW-1:0] exp_max_i;
  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int frame_id = 0, rd_id = 0, ov_id = 0;
  int last_wr_cyc = 0, first_rd_cyc = 0, first_ov_cyc = 0, last_out_cyc = 0;
  int overlap = 0, addr_stray = 0;

  // Output monitor: collects replay samples and event timestamps mid-cycle.
  always @(negedge clk) begin
    if (ram_wren) last_wr_cyc = cyc;
    if (ram_rden && rd_id != frame_id) begin first_rd_cyc = cyc; rd_id = frame_id; end
    if (out_valid) begin
      if (ov_id != frame_id) begin first_ov_cyc = cyc; ov_id = frame_id; end
      obs_q.push_back({out_data, out_idx, out_last});
      if (out_last) last_out_cyc = cyc;
    end
    if (ram_wren && ram_rden) overlap++;
    if (!ram_wren && !ram_rden && ram_addr != '0) addr_stray++;
  end

  function automatic int exp_addr(int k, int n, int m);
    case (m)
      1:       return n - 1 - k;
      2:       return (k + (n + 1) / 2) % n;
      default: return k;
    endcase
  endfunction

  // Reference replay order and peak for the frame held in stim.
  task automatic prepare(input int n, input int m);
    int a;
    smp_t s;
    frame_id++;
    exp_q.delete();
    obs_q.delete();
    for (int k = 0; k < n; k++) begin
      a   = exp_addr(k, n, m);
      s.d = stim[a];
      s.i = AW'(a);
      s.l = (k == n - 1);
      exp_q.push_back(s);
      if (k == 0 || s.d > exp_max_v) begin exp_max_v = s.d; exp_max_i = s.i; end
    end
  endtask

  task automatic start_frame(input int n, input int m);
    start = 1'b1; len_i = 12'(n); mode_i = 2'(m);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = stim[i];
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0;
      if (i != n - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input int budget, output int dc, output bit ok);
    ok = 1'b0; dc = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; dc = cyc; break; end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_held: outputs=%h want 0", all_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_idle: outputs=%h want 0", all_out); end
  endtask

  task automatic test_forward();
    int dc; bit ok; smp_t e, o;
    stim[0] = 5; stim[1] = 9; stim[2] = 2; stim[3] = 7;
    prepare(4, 0);
    start_frame(4, 0);
    n_tests++;
    if ({busy, in_ready} !== 2'b11) begin n_fail++; $display("FAIL fwd_accept: busy,in_ready=%b want 11", {busy, in_ready}); end
    send(4, 0);
    wait_done(40, dc, ok);
    n_tests++;
    if (!ok || dc - last_wr_cyc != 6) begin n_fail++; $display("FAIL fwd_done_lat: ok=%0b lat=%0d want 6", ok, dc - last_wr_cyc); end
    n_tests++;
    if (first_rd_cyc - last_wr_cyc != 1 || first_ov_cyc - last_wr_cyc != 2 || last_out_cyc - last_wr_cyc != 5) begin
      n_fail++; $display("FAIL fwd_timing: rd=%0d ov=%0d last=%0d want 1 2 5", first_rd_cyc - last_wr_cyc,
                         first_ov_cyc - last_wr_cyc, last_out_cyc - last_wr_cyc);
    end
    n_tests++;
    if (max_val !== exp_max_v || max_idx !== exp_max_i) begin n_fail++; $display("FAIL fwd_max: got %0d@%0d want %0d@%0d", max_val, max_idx, exp_max_v, exp_max_i); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL fwd_sample: got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b", o.d, o.i, o.l, e.d, e.i, e.l); end
    end
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL fwd_extra: %0d extra samples want 0", obs_q.size()); end
    @(posedge clk); #1;
    n_tests++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL fwd_end: busy,done=%b want 00", {busy, done}); end
  endtask

  task automatic test_reverse_gaps();
    int dc; bit ok; smp_t e, o;
    for (int i = 0; i < 5; i++) stim[i] = DW'(i + 1);
    prepare(5, 1);
    start_frame(5, 1);
    send(5, 1);
    @(posedge clk); #1;
    n_tests++;
    if ({in_ready, ram_rden} !== 2'b01) begin n_fail++; $display("FAIL rev_handoff: in_ready,ram_rden=%b want 01", {in_ready, ram_rden}); end
    wait_done(40, dc, ok);
    n_tests++;
    if (!ok || dc - last_wr_cyc != 7) begin n_fail++; $display("FAIL rev_done_lat: ok=%0b lat=%0d want 7", ok, dc - last_wr_cyc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL rev_sample: got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b", o.d, o.i, o.l, e.d, e.i, e.l); end
    end
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL rev_extra: %0d extra samples want 0", obs_q.size()); end
  endtask

  task automatic test_fftshift();
    int dc; bit ok; smp_t e, o;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 5; i++) stim[i] = (f == 0) ? DW'(10 * (i + 1)) : DW'(i + 1);
      prepare(4 + f, 2);
      start_frame(4 + f, 2);
      send(4 + f, 0);
      wait_done(40, dc, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL fft_done: no done within budget, want done"); end
      n_tests++;
      if (max_val !== exp_max_v || max_idx !== exp_max_i) begin n_fail++; $display("FAIL fft_max: got %0d@%0d want %0d@%0d", max_val, max_idx, exp_max_v, exp_max_i); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = '1;
        if (obs_q.size() > 0) o = obs_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL fft_sample: got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b", o.d, o.i, o.l, e.d, e.i, e.l); end
      end
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL fft_extra: %0d extra samples want 0", obs_q.size()); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_len_one();
    int dc; bit ok; smp_t e, o;
    stim[0] = 16'h002a;
    prepare(1, 0);
    start_frame(1, 0);
    send(1, 0);
    wait_done(20, dc, ok);
    n_tests++;
    if (!ok || dc - last_wr_cyc != 3 || first_ov_cyc != last_out_cyc) begin
      n_fail++; $display("FAIL one_timing: ok=%0b lat=%0d ov=%0d last=%0d want lat 3 and ov==last", ok, dc - last_wr_cyc, first_ov_cyc, last_out_cyc);
    end
    e = exp_q.pop_front(); o = '1;
    if (obs_q.size() > 0) o = obs_q.pop_front();
    n_tests++;
    if (o !== e || obs_q.size() != 0) begin n_fail++; $display("FAIL one_sample: got d=%0d i=%0d l=%0b extra=%0d want d=%0d i=%0d l=%0b extra=0", o.d, o.i, o.l, obs_q.size(), e.d, e.i, e.l); end
    @(posedge clk); #1;
  endtask

  task automatic test_len_max();
    int dc; bit ok; smp_t e, o;
    for (int i = 0; i < CAP; i++) stim[i] = DW'(i);
    prepare(CAP, 1);
    start_frame(CAP, 1);
    send(CAP, 0);
    wait_done(CAP + 50, dc, ok);
    n_tests++;
    if (!ok || dc - last_wr_cyc != CAP + 2) begin n_fail++; $display("FAIL max_done_lat: ok=%0b lat=%0d want %0d", ok, dc - last_wr_cyc, CAP + 2); end
    n_tests++;
    if (max_val !== exp_max_v || max_idx !== exp_max_i) begin n_fail++; $display("FAIL max_peak: got %0d@%0d want %0d@%0d", max_val, max_idx, exp_max_v, exp_max_i); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL max_sample: got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b", o.d, o.i, o.l, e.d, e.i, e.l); end
    end
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL max_extra: %0d extra samples want 0", obs_q.size()); end
    n_tests++;
    if (overlap != 0 || addr_stray != 0) begin n_fail++; $display("FAIL ram_ctrl: overlap=%0d stray_addr=%0d want 0 0", overlap, addr_stray); end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_len();
    int bad [2] = '{0, CAP + 1};
    for (int j = 0; j < 2; j++) begin
      start_frame(bad[j], 0);
      n_tests++;
      if ({err, busy, in_ready} !== 3'b100) begin n_fail++; $display("FAIL bad_len_%0d: err,busy,in_ready=%b want 100", bad[j], {err, busy, in_ready}); end
      @(posedge clk); #1;
      n_tests++;
      if ({err, busy} !== 2'b00) begin n_fail++; $display("FAIL bad_len_after_%0d: err,busy=%b want 00", bad[j], {err, busy}); end
    end
  endtask

  task automatic test_ties_ignored_start();
    int dc; bit ok; smp_t e, o;
    stim[0] = 3; stim[1] = 8; stim[2] = 8; stim[3] = 1;
    prepare(4, 0);
    start_frame(4, 0);
    send(4, 0);
    @(posedge clk); #1;
    start = 1'b1; len_i = 12'd3; mode_i = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if ({err, busy} !== 2'b01) begin n_fail++; $display("FAIL busy_start: err,busy=%b want 01", {err, busy}); end
    wait_done(40, dc, ok);
    n_tests++;
    if (!ok || max_val !== exp_max_v || max_idx !== exp_max_i) begin
      n_fail++; $display("FAIL tie_max: ok=%0b got %0d@%0d want %0d@%0d", ok, max_val, max_idx, exp_max_v, exp_max_i);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL tie_sample: got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b", o.d, o.i, o.l, e.d, e.i, e.l); end
    end
    repeat (2) begin @(posedge clk); #1; end
    n_tests++;
    if ({busy, obs_q.size() != 0} !== 2'b00) begin n_fail++; $display("FAIL tie_no_restart: busy=%0b extra=%0d want 0 0", busy, obs_q.size()); end
  endtask

  task automatic test_reset_mid();
    int dc; bit ok; smp_t e, o;
    for (int i = 0; i < 8; i++) stim[i] = DW'($urandom_range(1, 60000));
    prepare(8, 2);
    start_frame(8, 2);
    send(8, 0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL midreset: outputs=%h want 0", all_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) stim[i] = DW'($urandom_range(0, 65535));
    prepare(6, 2);
    start_frame(6, 2);
    send(6, 0);
    wait_done(40, dc, ok);
    n_tests++;
    if (!ok || dc - last_wr_cyc != 8 || max_val !== exp_max_v || max_idx !== exp_max_i) begin
      n_fail++; $display("FAIL post_reset: ok=%0b lat=%0d max=%0d@%0d want lat 8 max=%0d@%0d", ok, dc - last_wr_cyc, max_val, max_idx, exp_max_v, exp_max_i);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL post_reset_sample: got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b", o.d, o.i, o.l, e.d, e.i, e.l); end
    end
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL post_reset_extra: %0d extra samples want 0", obs_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_forward();
    test_reverse_gaps();
    test_fftshift();
    test_len_one();
    test_len_max();
    test_bad_len();
    test_ties_ignored_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_seq_ctrl.md
# frame_seq_ctrl

Frame sequencer for the 16×2048 sample-buffer datapath. It captures one frame of `len` samples from a valid-qualified input stream into an external single-port RAM. It then replays the frame in a selected address order: forward, reverse, or fftshift. During replay it tracks the maximum sample value and its index. It replaces free-running counter windows with a start/done handshake and owns every RAM control signal.

## Interface
Parameters:
- `DW`, default 16: sample width.
- `AW`, default 11: RAM address width. Frame capacity is 2^AW.

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: frame request pulse. Sampled only in IDLE.
- `mode`, in, 2: replay order. 0 = forward, 1 = reverse, 2 = fftshift, 3 = forward. Latched on accepted `start`.
- `len`, in, AW+1: frame length, valid range 1..2^AW. Latched on accepted `start`.
- `in_valid`, in, 1: input sample valid.
- `in_data`, in, DW: input sample.
- `in_ready`, out, 1: high throughout CAPTURE.
- `ram_addr`, out, AW: RAM address.
- `ram_wren`, out, 1: RAM write enable.
- `ram_rden`, out, 1: RAM read enable.
- `ram_wdata`, out, DW: RAM write data.
- `ram_rdata`, in, DW: RAM read data. Read latency is 1 cycle.
- `out_valid`, out, 1: replay sample valid. There is no backpressure.
- `out_data`, out, DW: replay sample.
- `out_idx`, out, AW: original capture index of `out_data`.
- `out_last`, out, 1: marks the final replay sample.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse at frame end.
- `max_val`, out, DW: maximum replayed value. Valid from `done` until the next accepted `start`.
- `max_idx`, out, AW: capture index of `max_val`.
- `err`, out, 1: one-cycle pulse on a rejected `start`.

## Operation
- States: IDLE → CAPTURE → REPLAY → DRAIN → DONE → IDLE.
- IDLE:
  - `start` with `len` in 1..2^AW: latch `len` and `mode`, clear `wr_ptr`, `rd_k` and the max tracker, go to CAPTURE.
  - `start` with `len` = 0 or `len` > 2^AW: pulse `err`, stay in IDLE.
- CAPTURE:
  - `in_ready` = 1.
  - On each `in_valid`: `ram_wren` = 1, `ram_addr` = `wr_ptr`, `ram_wdata` = `in_data`, then `wr_ptr` += 1.
  - Gaps in `in_valid` stall capture without limit.
  - When the write with `wr_ptr` = `len`−1 completes, go to REPLAY.
- REPLAY:
  - One read per cycle: `ram_rden` = 1 for k = 0..`len`−1.
  - Read address by mode:
    - forward: k.
    - reverse: `len`−1−k.
    - fftshift: with h = (`len`+1)>>1, address = k+h if k+h < `len`, otherwise k+h−`len`.
  - Address arithmetic is computed in AW+1 bits with no modulo operator (compare and subtract).
  - After k = `len`−1, go to DRAIN.
- DRAIN: one cycle. This covers the last RAM read latency.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- Replay output:
  - `out_valid`, `out_idx` and `out_last` are the read-cycle `ram_rden`, address and (k = `len`−1) flag, each delayed 1 cycle.
  - `out_data` = `ram_rdata`.
- Max tracker:
  - Unsigned compare.
  - The first `out_valid` sample loads the tracker unconditionally.
  - Later samples update it only when strictly greater, so the earliest occurrence of a tie wins.
- `start` while `busy` is ignored. It raises no `err`.
- `in_valid` outside CAPTURE is ignored. `in_ready` = 0 there.
- `ram_wren` and `ram_rden` are never high together.
- `ram_addr` = 0 when both enables are low.

## Timing
- Reset values: every output is 0 (`in_ready`, `ram_*`, `out_*`, `busy`, `done`, `max_val`, `max_idx`, `err`). State = IDLE.
- `start` accepted at cycle t:
  - `busy` = 1 from t+1.
  - `in_ready` = 1 from t+1.
- Last capture write at cycle c:
  - `in_ready` = 0 at c+1.
  - First `ram_rden` at c+1.
  - First `out_valid` at c+2.
  - `out_last` at c+1+`len`.
  - `done` at c+2+`len`.
  - `busy` = 0 at c+3+`len`.
- `max_val` and `max_idx` are final on the `done` cycle.
- Reset asserted mid-frame: all outputs return to reset values asynchronously and the frame is abandoned. RAM contents are don't-care.
- `len` = 1: REPLAY lasts one cycle. `out_valid` and `out_last` coincide.
- `len` = 2^AW: the 2^AW−1 → 0 wrap is never reached, because capture ends at the final address.

## Test plan
- Forward: mode 0, `len` 4, input 5, 9, 2, 7 → output 5, 9, 2, 7 with `out_idx` 0..3; `max_val` = 9, `max_idx` = 1; `done` exactly 6 cycles after the last write cycle.
- Reverse with gaps: mode 1, `len` 5, input 1..5 with one idle cycle between samples → output 5, 4, 3, 2, 1 with `out_idx` 4..0; `out_last` on value 1.
- fftshift: mode 2, `len` 4, input 10, 20, 30, 40 → output 30, 40, 10, 20. Then `len` 5, input 1..5 → output 4, 5, 1, 2, 3.
- Length limits:
  - `len` 1 → a single output with `out_last` = 1.
  - `len` 2048 with a ramp input, reverse mode → first output 2047, last output 0.
  - `len` 0 or 2049 → `err` pulse, `busy` stays 0.
- Ties and ignored start: input 3, 8, 8, 1 → `max_idx` = 1. A `start` during REPLAY → ignored, no `err`, the frame completes normally.
- Reset mid-REPLAY: assert `rst_n` = 0 → all outputs 0 immediately. A fresh frame afterwards completes correctly.
